truth_table_sweep: RTL and testbench

TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

---
 rtl/truth_table_sweep_if.sv | 14 +
 rtl/truth_table_sweep.sv | 104 ++++++++++
 tb/tb_truth_table_sweep.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweep_if.sv
// Control/status bundle between a sweep requester and the sweep engine.
interface truth_table_sweep_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       pass;

  // Requester drives start/abort and observes status.
  modport master (output start, abort, input busy, done, table_out, pass);
  // Sweep engine consumes requests and reports status.
  modport slave  (input start, abort, output busy, done, table_out, pass);
endinterface

// File: rtl/truth_table_sweep.sv
// Walks a 3-input logic stage through all eight input vectors, holds each
// for SETTLE cycles, captures the stage output into an 8-bit truth table
// and compares it against a golden table.
module truth_table_sweep #(
  parameter int unsigned SETTLE   = 4,
  parameter logic [7:0]  EXPECTED = 8'h66
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweep_if.slave    ctrl,
  input  logic                  dut_out,
  output logic                  in1,
  output logic                  in2,
  output logic                  in3
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tbl_q, tbl_d;
  logic       pass_q, pass_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] sampled;

  // Next-state logic: vector stepping, settle counting and table capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    pass_d  = pass_q;
    sampled = tbl_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl.start) begin
          state_d = S_SETTLE;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          tbl_d   = 8'h00;
          pass_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (ctrl.abort) begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          tbl_d   = 8'h00;
          pass_d  = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          sampled[idx_q] = dut_out;
          tbl_d = sampled;
          cnt_d = 8'd0;
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
            pass_d  = (sampled == EXPECTED);
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
    vec_d = (state_d == S_SETTLE) ? idx_d : 3'b000;
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      tbl_q   <= 8'h00;
      pass_q  <= 1'b0;
      vec_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
    end
  end

  assign in1            = vec_q[2];
  assign in2            = vec_q[1];
  assign in3            = vec_q[0];
  assign ctrl.busy      = (state_q == S_SETTLE);
  assign ctrl.done      = (state_q == S_DONE);
  assign ctrl.table_out = tbl_q;
  assign ctrl.pass      = pass_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench: three sweep engines (SETTLE 4, 2, 1) driving modelled
// logic stages, checked cycle by cycle against hand-computed values.
module tb_truth_table_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecCount = 0;
  int   missCount = 0;
  int   doneCnt4 = 0;

  truth_table_sweep_if if4 ();
  truth_table_sweep_if if2 ();
  truth_table_sweep_if if1 ();

  logic a4, b4, c4, out4;
  logic a2, b2, c2, out2;
  logic a1, b1, c1, out1;
  logic stuck4 = 1'b0;

  always #5 clk = ~clk;

  // Stage models: XOR of in2/in3 (optionally stuck at 0), a registered
  // copy for the SETTLE=2 engine, and a plain XOR for SETTLE=1.
  assign out4 = stuck4 ? 1'b0 : (b4 ^ c4);
  always @(posedge clk) out2 <= b2 ^ c2;
  assign out1 = b1 ^ c1;

  always @(negedge clk) if (if4.done) doneCnt4++;

  truth_table_sweep #(.SETTLE(4), .EXPECTED(8'h66)) u4 (
    .clk(clk), .rst_n(rst_n), .ctrl(if4), .dut_out(out4), .in1(a4), .in2(b4), .in3(c4));
  truth_table_sweep #(.SETTLE(2), .EXPECTED(8'h66)) u2 (
    .clk(clk), .rst_n(rst_n), .ctrl(if2), .dut_out(out2), .in1(a2), .in2(b2), .in3(c2));
  truth_table_sweep #(.SETTLE(1), .EXPECTED(8'h66)) u1 (
    .clk(clk), .rst_n(rst_n), .ctrl(if1), .dut_out(out1), .in1(a1), .in2(b1), .in3(c1));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle4(input string tag, input logic [7:0] expTable, input logic expPass);
    checkOutput({tag, "_vec"}, 32'({a4, b4, c4}), 32'd0);
    checkOutput({tag, "_busy"}, 32'(if4.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(if4.done), 32'd0);
    checkOutput({tag, "_table"}, 32'(if4.table_out), 32'(expTable));
    checkOutput({tag, "_pass"}, 32'(if4.pass), 32'(expPass));
  endtask

  // Full SETTLE=4 sweep with per-cycle vector checks; optionally pokes
  // start mid-sweep and raises abort during the DONE cycle.
  task automatic applyStimulus(input logic [7:0] expTable, input logic expPass,
                               input bit pokeStart, input bit abortAtDone);
    @(negedge clk) if4.start = 1'b1;
    @(posedge clk); #1 if4.start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c <= 32) begin
        checkOutput("sweep4_vec", 32'({a4, b4, c4}), 32'((c - 1) / 4));
        checkOutput("sweep4_busy", 32'(if4.busy), 32'd1);
        checkOutput("sweep4_done_low", 32'(if4.done), 32'd0);
      end else begin
        checkOutput("sweep4_done", 32'(if4.done), 32'd1);
        checkOutput("sweep4_busy_done", 32'(if4.busy), 32'd0);
        checkOutput("sweep4_table", 32'(if4.table_out), 32'(expTable));
        checkOutput("sweep4_pass", 32'(if4.pass), 32'(expPass));
      end
      if (pokeStart && c == 10) if4.start = 1'b1;
      if (pokeStart && c == 11) if4.start = 1'b0;
      if (abortAtDone && c == 33) if4.abort = 1'b1;
    end
    @(negedge clk);
    if4.abort = 1'b0;
    checkIdle4("after_done4", expTable, expPass);
  endtask

  initial begin
    int doneFirst;
    int doneSecond;
    int doneSeen;
    int doneBefore;
    if4.start = 0; if4.abort = 0;
    if2.start = 0; if2.abort = 0;
    if1.start = 0; if1.abort = 0;

    // Reset state
    #2;
    checkIdle4("reset", 8'h00, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkIdle4("idle_after_reset", 8'h00, 1'b0);

    // XOR stage, start poked mid-sweep must be ignored
    applyStimulus(8'h66, 1'b1, 1'b1, 1'b0);
    checkOutput("single_done_pulse", 32'(doneCnt4), 32'd1);

    // Stuck-at-0 stage
    stuck4 = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("stuck_done_pulses", 32'(doneCnt4), 32'd2);
    stuck4 = 1'b0;

    // Abort during vector 3
    doneBefore = doneCnt4;
    @(negedge clk) if4.start = 1'b1;
    @(posedge clk); #1 if4.start = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("pre_abort_vec", 32'({a4, b4, c4}), 32'd3);
    checkOutput("pre_abort_table", 32'(if4.table_out), 32'h06);
    if4.abort = 1'b1;
    @(negedge clk) if4.abort = 1'b0;
    checkIdle4("abort", 8'h00, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", 32'(doneCnt4 - doneBefore), 32'd0);

    // Recovery sweep with abort held during DONE
    applyStimulus(8'h66, 1'b1, 1'b0, 1'b1);

    // start held high: back-to-back sweeps with a one-cycle IDLE gap
    doneFirst = 0; doneSecond = 0; doneSeen = 0;
    @(negedge clk) if4.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      if (if4.done) begin
        doneSeen++;
        if (doneSeen == 1) doneFirst = c;
        if (doneSeen == 2) doneSecond = c;
      end
      if (c == 34) checkOutput("gap_busy", 32'(if4.busy), 32'd0);
      if (c == 40) checkOutput("second_sweep_vec", 32'({a4, b4, c4}), 32'd1);
      if (c == 68) begin
        checkOutput("held_gap2_busy", 32'(if4.busy), 32'd0);
        if4.start = 1'b0;
      end
    end
    checkOutput("held_done_count", 32'(doneSeen), 32'd2);
    checkOutput("held_done_first", 32'(doneFirst), 32'd33);
    checkOutput("held_done_second", 32'(doneSecond), 32'd67);
    repeat (3) @(negedge clk);
    checkIdle4("held_end", 8'h66, 1'b1);

    // Asynchronous reset during vector 5
    doneBefore = doneCnt4;
    @(negedge clk) if4.start = 1'b1;
    @(posedge clk); #1 if4.start = 1'b0;
    repeat (22) @(negedge clk);
    checkOutput("pre_reset_vec", 32'({a4, b4, c4}), 32'd5);
    #2 rst_n = 1'b0;
    #1 checkIdle4("async_reset", 8'h00, 1'b0);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("reset_no_done", 32'(doneCnt4 - doneBefore), 32'd0);
    checkOutput("reset_stays_idle", 32'(if4.busy), 32'd0);

    // SETTLE=2 with registered stage delay: done at cycle 17
    @(negedge clk) if2.start = 1'b1;
    @(posedge clk); #1 if2.start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c <= 16) checkOutput("sweep2_vec", 32'({a2, b2, c2}), 32'((c - 1) / 2));
      checkOutput("sweep2_done", 32'(if2.done), 32'(c == 17));
    end
    checkOutput("sweep2_table", 32'(if2.table_out), 32'h66);
    checkOutput("sweep2_pass", 32'(if2.pass), 32'd1);

    // SETTLE=1: one vector per cycle, done at cycle 9
    @(negedge clk) if1.start = 1'b1;
    @(posedge clk); #1 if1.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 8) checkOutput("sweep1_vec", 32'({a1, b1, c1}), 32'(c - 1));
      checkOutput("sweep1_done", 32'(if1.done), 32'(c == 9));
    end
    checkOutput("sweep1_table", 32'(if1.table_out), 32'h66);
    checkOutput("sweep1_pass", 32'(if1.pass), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
